// File: rtl/spi_cmd_pkg.sv
// Shared definitions for the SPI command controller: FSM states, command byte
// bit positions and the default bus address width.
package spi_cmd_pkg;

  localparam int ADDR_WIDTH_DEFAULT = 16;
  localparam int CMD_WR_BIT         = 7;
  localparam int CMD_INC_BIT        = 6;

  typedef enum logic [2:0] {
    S_CMD     = 3'd0,
    S_ADDR_HI = 3'd1,
    S_ADDR_LO = 3'd2,
    S_DATA    = 3'd3,
    S_BUS     = 3'd4
  } state_e;

endpackage

// File: rtl/spi_cmd_ctrl_if.sv
// Parallel bus between the SPI command controller (master) and the register
// bus it drives (slave).
interface spi_cmd_ctrl_if
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) ();

  logic [ADDR_WIDTH-1:0] bus_addr;
  logic [7:0]            bus_wr_data;
  logic                  bus_rd_req;
  logic                  bus_wr_req;
  logic                  bus_ack;
  logic [7:0]            bus_rd_data;

  modport master (
    output bus_addr, bus_wr_data, bus_rd_req, bus_wr_req,
    input  bus_ack, bus_rd_data
  );

  modport slave (
    input  bus_addr, bus_wr_data, bus_rd_req, bus_wr_req,
    output bus_ack, bus_rd_data
  );

endinterface

// File: rtl/sync2.sv
// Two-flop synchronizer for a level signal; both flops reset to 1 so an idle
// (deasserted, active-low) input is assumed out of reset.
module sync2 (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 1'b1;
      q_o    <= 1'b1;
    end else begin
      meta_q <= d_i;
      q_o    <= meta_q;
    end
  end

endmodule

// File: rtl/spi_cmd_ctrl.sv
// SPI command decoder: cmd / addr-hi / addr-lo / data bytes become bus reads and
// writes. Define SPI_CMD_AUTOINC_EN to honour the auto-increment command bit.
module spi_cmd_ctrl
  import spi_cmd_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEFAULT
) (
  input  logic                  sys_clk,
  input  logic                  sys_reset_n,
  input  logic                  spi_cs_n,
  input  logic [7:0]            rx_byte,
  input  logic                  rx_strobe,
  output logic [7:0]            tx_byte,
  spi_cmd_ctrl_if.master        bus,
  output logic                  busy,
  output logic                  overrun
);

  logic                  cs_n_sync;
  state_e                state_q, state_d;
  logic                  cmd_wr_q, cmd_wr_d;
  logic                  cmd_inc_q, cmd_inc_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic [7:0]            tx_q, tx_d;
  logic                  rd_req_q, rd_req_d;
  logic                  wr_req_q, wr_req_d;
  logic                  ovr_q, ovr_d;
  logic [15:0]           addr_ext;
  logic [15:0]           addr_hi_ld;
  logic [15:0]           addr_lo_ld;

  sync2 u_cs_sync (
    .clk_i  (sys_clk),
    .rst_ni (sys_reset_n),
    .d_i    (spi_cs_n),
    .q_o    (cs_n_sync)
  );

  // Byte loads go through a 16-bit view so narrower buses just drop the top bits.
  assign addr_ext   = 16'(addr_q);
  assign addr_hi_ld = {rx_byte, addr_ext[7:0]};
  assign addr_lo_ld = {addr_ext[15:8], rx_byte};

  always_comb begin
    state_d   = state_q;
    cmd_wr_d  = cmd_wr_q;
    cmd_inc_d = cmd_inc_q;
    addr_d    = addr_q;
    wr_data_d = wr_data_q;
    tx_d      = tx_q;
    rd_req_d  = rd_req_q;
    wr_req_d  = wr_req_q;
    ovr_d     = ovr_q;

    if (cs_n_sync && state_q != S_BUS) begin
      state_d = S_CMD;
    end else begin
      case (state_q)
        S_CMD: if (rx_strobe) begin
          cmd_wr_d = rx_byte[CMD_WR_BIT];
`ifdef SPI_CMD_AUTOINC_EN
          cmd_inc_d = rx_byte[CMD_INC_BIT];
`else
          cmd_inc_d = 1'b0;
`endif
          state_d = S_ADDR_HI;
        end
        S_ADDR_HI: if (rx_strobe) begin
          addr_d  = addr_hi_ld[ADDR_WIDTH-1:0];
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: if (rx_strobe) begin
          addr_d = addr_lo_ld[ADDR_WIDTH-1:0];
          if (cmd_wr_q) begin
            state_d = S_DATA;
          end else begin
            rd_req_d = 1'b1;
            state_d  = S_BUS;
          end
        end
        S_DATA: if (rx_strobe) begin
          // For reads the incoming byte is only a dummy clocking out the next datum.
          if (cmd_wr_q) begin
            wr_data_d = rx_byte;
            wr_req_d  = 1'b1;
          end else begin
            rd_req_d  = 1'b1;
          end
          state_d = S_BUS;
        end
        S_BUS: if (bus.bus_ack) begin
          rd_req_d = 1'b0;
          wr_req_d = 1'b0;
          if (!cmd_wr_q) tx_d = bus.bus_rd_data;
          if (cmd_inc_q) addr_d = addr_q + ADDR_WIDTH'(1);
          state_d = cs_n_sync ? S_CMD : S_DATA;
        end
        default: state_d = S_CMD;
      endcase
    end

    if (cs_n_sync)
      ovr_d = 1'b0;
    else if (state_q == S_BUS && rx_strobe)
      ovr_d = 1'b1;

    if (state_d == S_CMD || state_d == S_ADDR_HI || state_d == S_ADDR_LO)
      tx_d = 8'h00;
  end

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state_q   <= S_CMD;
      cmd_wr_q  <= 1'b0;
      cmd_inc_q <= 1'b0;
      addr_q    <= '0;
      wr_data_q <= 8'h00;
      tx_q      <= 8'h00;
      rd_req_q  <= 1'b0;
      wr_req_q  <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_wr_q  <= cmd_wr_d;
      cmd_inc_q <= cmd_inc_d;
      addr_q    <= addr_d;
      wr_data_q <= wr_data_d;
      tx_q      <= tx_d;
      rd_req_q  <= rd_req_d;
      wr_req_q  <= wr_req_d;
      ovr_q     <= ovr_d;
    end
  end

  assign tx_byte         = tx_q;
  assign bus.bus_addr    = addr_q;
  assign bus.bus_wr_data = wr_data_q;
  assign bus.bus_rd_req  = rd_req_q;
  assign bus.bus_wr_req  = wr_req_q;
  assign busy            = rd_req_q | wr_req_q;
  assign overrun         = ovr_q;

endmodule

// File: tb/tb_spi_cmd_ctrl.sv
// Randomized self-checking bench for spi_cmd_ctrl against a transaction-level
// model of addresses, data and flags.
module tb_spi_cmd_ctrl;
  import spi_cmd_pkg::*;

  localparam int AW = 16;
`ifdef SPI_CMD_AUTOINC_EN
  localparam bit INC_EN = 1'b1;
`else
  localparam bit INC_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cs_n = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_strobe = 1'b0;
  logic [7:0] tx_byte;
  logic       busy;
  logic       overrun;

  spi_cmd_ctrl_if #(.ADDR_WIDTH(AW)) bus_if ();

  spi_cmd_ctrl #(.ADDR_WIDTH(AW)) dut (
    .sys_clk     (clk),
    .sys_reset_n (rst_n),
    .spi_cs_n    (cs_n),
    .rx_byte     (rx_byte),
    .rx_strobe   (rx_strobe),
    .tx_byte     (tx_byte),
    .bus         (bus_if.master),
    .busy        (busy),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;

  logic [7:0] wbuf [8];
  logic [7:0] rbuf [8];

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    rx_byte   = b;
    rx_strobe = 1'b1;
    tick();
    rx_strobe = 1'b0;
  endtask

  // One full transaction of n bus accesses; ack arrives after min..max wait cycles.
  task automatic run_txn(input bit wr, input bit inc, input logic [15:0] a, input int n,
                         input int min_dly, input int max_dly, input bit inj);
    logic [AW-1:0] exp_a;
    bit            ovr_exp;
    int            dly;
    exp_a   = a[AW-1:0];
    ovr_exp = 1'b0;
    cs_n = 1'b0;
    repeat (3) tick();
    send({wr, inc, 6'($urandom)});
    check_eq("tx_after_cmd", tx_byte, 0);
    send(a[15:8]);
    check_eq("tx_after_ahi", tx_byte, 0);
    check_eq("idle_after_ahi", busy, 0);
    send(a[7:0]);
    for (int i = 0; i < n; i++) begin
      if (wr) send(wbuf[i]);
      else if (i > 0) send(8'($urandom));
      check_eq("req_seen", busy, 1);
      if (!busy) begin
        cs_n = 1'b1;
        repeat (4) tick();
        return;
      end
      check_eq("rd_req", bus_if.bus_rd_req, !wr);
      check_eq("wr_req", bus_if.bus_wr_req, wr);
      check_eq("addr", bus_if.bus_addr, exp_a);
      if (wr) check_eq("wdata", bus_if.bus_wr_data, wbuf[i]);
      dly = $urandom_range(max_dly, min_dly);
      for (int k = 0; k < dly; k++) begin
        if (inj && k == 0) begin
          rx_byte   = 8'($urandom);
          rx_strobe = 1'b1;
          ovr_exp   = 1'b1;
        end
        tick();
        rx_strobe = 1'b0;
        check_eq("hold_req", busy, 1);
        check_eq("hold_addr", bus_if.bus_addr, exp_a);
      end
      check_eq("overrun", overrun, ovr_exp);
      bus_if.bus_ack     = 1'b1;
      bus_if.bus_rd_data = rbuf[i];
      tick();
      bus_if.bus_ack     = 1'b0;
      bus_if.bus_rd_data = 8'($urandom);
      check_eq("req_drop", busy, 0);
      if (!wr) check_eq("tx_rd", tx_byte, rbuf[i]);
      if (inc && INC_EN) exp_a = exp_a + AW'(1);
      check_eq("addr_next", bus_if.bus_addr, exp_a);
    end
    cs_n = 1'b1;
    repeat (4) tick();
    check_eq("ovr_clr", overrun, 0);
    check_eq("tx_idle", tx_byte, 0);
    check_eq("busy_idle", busy, 0);
  endtask

  task automatic abort_after(input int nbytes);
    cs_n = 1'b0;
    repeat (3) tick();
    for (int i = 0; i < nbytes; i++) send(8'($urandom) | 8'h80);
    cs_n = 1'b1;
    repeat (4) tick();
    check_eq("abort_busy", busy, 0);
    check_eq("abort_tx", tx_byte, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus_if.bus_ack     = 1'b0;
    bus_if.bus_rd_data = 8'h00;
    repeat (3) tick();
    check_eq("rst_addr", bus_if.bus_addr, 0);
    check_eq("rst_wdata", bus_if.bus_wr_data, 0);
    check_eq("rst_tx", tx_byte, 0);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_ovr", overrun, 0);
    rst_n = 1'b1;
    tick();

    wbuf[0] = 8'hA5;
    run_txn(1'b1, 1'b0, 16'h1234, 1, 2, 6, 1'b0);

    wbuf[0] = 8'h11; wbuf[1] = 8'h22; wbuf[2] = 8'h33;
    run_txn(1'b1, 1'b1, 16'h00FE, 3, 0, 0, 1'b0);

    rbuf[0] = 8'h5A; rbuf[1] = 8'h6B;
    run_txn(1'b0, 1'b1, 16'h2000, 2, 0, 3, 1'b0);

    wbuf[0] = 8'h77;
    run_txn(1'b1, 1'b0, 16'h4321, 1, 10, 10, 1'b1);

    abort_after(2);
    rbuf[0] = 8'hC3;
    run_txn(1'b0, 1'b0, 16'hBEEF, 1, 0, 2, 1'b0);

    abort_after(3);
    wbuf[0] = 8'h01; wbuf[1] = 8'h02;
    run_txn(1'b1, 1'b1, 16'hFFFF, 2, 0, 1, 1'b0);

    for (int t = 0; t < 30; t++) begin
      for (int i = 0; i < 8; i++) begin
        wbuf[i] = 8'($urandom);
        rbuf[i] = 8'($urandom);
      end
      run_txn(1'($urandom), 1'($urandom), 16'($urandom), $urandom_range(4, 1),
              1, 4, ($urandom_range(3, 0) == 0));
    end

    // Reset while a write is waiting for its ack.
    cs_n = 1'b0;
    repeat (3) tick();
    send(8'h80); send(8'h12); send(8'h34); send(8'hA5);
    check_eq("pre_rst_busy", busy, 1);
    rst_n = 1'b0;
    #1;
    check_eq("mid_rst_busy", busy, 0);
    check_eq("mid_rst_wr", bus_if.bus_wr_req, 0);
    check_eq("mid_rst_rd", bus_if.bus_rd_req, 0);
    check_eq("mid_rst_addr", bus_if.bus_addr, 0);
    check_eq("mid_rst_wdata", bus_if.bus_wr_data, 0);
    check_eq("mid_rst_tx", tx_byte, 0);
    check_eq("mid_rst_ovr", overrun, 0);
    cs_n = 1'b1;
    tick();
    rst_n = 1'b1;
    repeat (2) tick();

    rbuf[0] = 8'h9C;
    run_txn(1'b0, 1'b0, 16'h0042, 1, 0, 3, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/spi_cmd_ctrl.md
SPI_CMD_CTRL -- requirements
Module: spi_cmd_ctrl

Interface
REQ-001 Parameter: ADDR_WIDTH, 16, width of bus address; legal 8..16.
REQ-002 sys_clk  in  1  system clock; all state updates on its rising edge.
REQ-003 sys_reset_n  in  1  asynchronous, active-low reset.
REQ-004 spi_cs_n  in  1  raw SPI chip select, asynchronous to sys_clk; low = transaction active.
REQ-005 rx_byte  in  8  byte received by the SPI byte shifter; stable whenever rx_strobe is high.
REQ-006 rx_strobe  in  1  one-sys_clk pulse per received byte, already in the sys_clk domain.
REQ-007 tx_byte  out  8  byte the SPI byte shifter sends during the next byte slot.
REQ-008 bus_addr  out  ADDR_WIDTH  bus address.
REQ-009 bus_wr_data  out  8  bus write data.
REQ-010 bus_rd_req / bus_wr_req  out  1 each  bus request strobes, mutually exclusive.
REQ-011 bus_ack  in  1  bus completion; bus_rd_data is valid in the same cycle.
REQ-012 bus_rd_data  in  8  bus read data.
REQ-013 busy  out  1  high while a bus request is outstanding.
REQ-014 overrun  out  1  sticky flag: a byte arrived while busy.

Function
REQ-015 spi_cs_n SHALL pass through a 2-flop synchronizer; all references to cs_n below mean the synchronized value, with 2 cycles of latency.
REQ-016 States SHALL be S_CMD, S_ADDR_HI, S_ADDR_LO, S_DATA, S_BUS.
REQ-017 Command byte format SHALL be: bit7 = write(1) or read(0); bit6 = auto-increment; bits5:0 ignored.
REQ-018 S_CMD SHALL latch the command on rx_strobe and go to S_ADDR_HI.
REQ-019 S_ADDR_HI SHALL load the address high byte and go to S_ADDR_LO; when ADDR_WIDTH < 16, upper bits are truncated.
REQ-020 S_ADDR_LO, on rx_strobe: load the low byte; for a write, go to S_DATA; for a read, assert bus_rd_req and go to S_BUS.
REQ-021 S_DATA, on rx_strobe: load bus_wr_data with rx_byte, assert bus_wr_req, and go to S_BUS.
REQ-022 S_BUS SHALL hold the request and bus_addr stable until bus_ack is sampled high, then deassert the request on the next cycle.
REQ-023 On a read ack, S_BUS SHALL load tx_byte with bus_rd_data in the ack cycle.
REQ-024 After an ack, S_BUS SHALL go to S_DATA; if auto-increment is set, bus_addr increments by 1, wrapping at 2^ADDR_WIDTH.
REQ-025 S_DATA for a read command, on rx_strobe: treat rx_byte as a dummy byte, assert bus_rd_req, and go to S_BUS (streaming read).
REQ-026 rx_strobe in S_BUS SHALL be dropped, SHALL set overrun, and SHALL NOT alter any state.
REQ-027 cs_n high SHALL force S_CMD from any state except S_BUS; S_BUS SHALL complete its handshake and then enter S_CMD.
REQ-028 cs_n high SHALL clear overrun.
REQ-029 tx_byte SHALL be 8'h00 while in S_CMD, S_ADDR_HI and S_ADDR_LO.
REQ-030 busy SHALL equal bus_rd_req | bus_wr_req.

Reset
REQ-031 Reset SHALL set: state S_CMD, tx_byte 8'h00, bus_addr 0, bus_wr_data 0, both requests 0, busy 0, overrun 0, synchronizer flops 1.
REQ-032 Reset mid-transaction SHALL drop all requests immediately, with no ack required.

Configuration
REQ-033 Macro SPI_CMD_AUTOINC_EN. When defined, command bit6 enables address increment after each ack.
REQ-034 When SPI_CMD_AUTOINC_EN is undefined, bit6 SHALL be ignored and bus_addr SHALL stay constant for the whole transaction.

Structure
REQ-035 A shared package spi_cmd_pkg SHALL hold the state enum, the command bit positions (CMD_WR_BIT=7, CMD_INC_BIT=6) and the ADDR_WIDTH default.
REQ-036 The 2-flop synchronizer SHALL be the sub-module sync2, reset to 1.

Verification
REQ-037 Write test: cs_n low; bytes 80,12,34,A5 -> one bus_wr_req at bus_addr 16'h1234 with data A5; the request holds until ack.
REQ-038 Auto-increment write: bytes C0,00,FE,11,22,33 with instant ack -> writes at 00FE, 00FF, 0100.
REQ-039 Streaming read with auto-increment: bytes 40,20,00,xx,xx; bus returns 5A then 6B -> tx_byte is 5A after the first ack and 6B after the second; addresses are 2000 and 2001.
REQ-040 Overrun: rx_strobe during a 10-cycle-delayed ack -> overrun=1, byte dropped, state unchanged; cs_n high clears overrun.
REQ-041 Abort: cs_n high after 2 bytes -> S_CMD with no bus request; the next transaction decodes correctly.
REQ-042 Reset asserted during S_BUS -> requests 0 the same cycle, all outputs at reset values.
